reg_hazard_scoreboard: RTL



---
 rtl/reg_hazard_scoreboard.sv | 107 ++++++++++
 1 files changed

// File: rtl/reg_hazard_scoreboard.sv
// Pending-write scoreboard: tracks in-flight destination tags and blocks issue
// on RAW/WAW hazards until the matching slot is retired by writeback.
module reg_hazard_scoreboard #(
    parameter int REG_WIDTH  = 5,
    parameter int DEPTH      = 4,
    parameter int SLOT_WIDTH = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_issue_valid,
    input  logic [REG_WIDTH-1:0]  i_issue_rs1,
    input  logic [REG_WIDTH-1:0]  i_issue_rs2,
    input  logic [REG_WIDTH-1:0]  i_issue_rd,
    input  logic                  i_issue_rd_en,
    output logic                  o_issue_ready,
    output logic [SLOT_WIDTH-1:0] o_issue_slot,
    input  logic                  i_wb_valid,
    input  logic [SLOT_WIDTH-1:0] i_wb_slot,
    input  logic                  i_flush,
    output logic [SLOT_WIDTH:0]   o_inflight,
    output logic                  o_full
);

    logic [DEPTH-1:0]     r_valid;
    logic [REG_WIDTH-1:0] r_tag [DEPTH];
    logic [SLOT_WIDTH:0]  r_inflight;

    logic [DEPTH-1:0]     w_rs1_match;
    logic [DEPTH-1:0]     w_rs2_match;
    logic [DEPTH-1:0]     w_rd_match;
    logic                 w_alloc;
    logic                 w_rs1_hz;
    logic                 w_rs2_hz;
    logic                 w_waw_hz;
    logic                 w_fire;
    logic [SLOT_WIDTH-1:0] w_free_slot;
    logic [DEPTH-1:0]     w_valid_next;
    logic [SLOT_WIDTH:0]  w_inflight_next;

    // One comparator triple per slot: the 1-vs-N match against every valid tag.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign w_rs1_match[gi] = r_valid[gi] && (r_tag[gi] == i_issue_rs1);
            assign w_rs2_match[gi] = r_valid[gi] && (r_tag[gi] == i_issue_rs2);
            assign w_rd_match[gi]  = r_valid[gi] && (r_tag[gi] == i_issue_rd);
        end
    endgenerate

    assign w_alloc  = i_issue_rd_en && (i_issue_rd != '0);
    assign w_rs1_hz = (i_issue_rs1 != '0) && (|w_rs1_match);
    assign w_rs2_hz = (i_issue_rs2 != '0) && (|w_rs2_match);
    assign w_waw_hz = w_alloc && (|w_rd_match);

    assign o_full        = (r_inflight == (SLOT_WIDTH+1)'(DEPTH));
    assign o_inflight    = r_inflight;
    assign o_issue_ready = !i_flush && !w_rs1_hz && !w_rs2_hz && !w_waw_hz
                           && !(w_alloc && o_full);
    assign w_fire        = i_issue_valid && o_issue_ready;
    assign o_issue_slot  = w_free_slot;

    // Priority encode the lowest free slot; falls back to 0 when full.
    always_comb begin
        w_free_slot = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_slot = SLOT_WIDTH'(i);
            end
        end
    end

    // Free slot comes from pre-writeback state, so it never collides with i_wb_slot.
    always_comb begin
        w_valid_next = r_valid;
        if (i_wb_valid) begin
            w_valid_next[i_wb_slot] = 1'b0;
        end
        if (w_fire && w_alloc) begin
            w_valid_next[w_free_slot] = 1'b1;
        end
        if (i_flush) begin
            w_valid_next = '0;
        end
        w_inflight_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_inflight_next = w_inflight_next + {{SLOT_WIDTH{1'b0}}, w_valid_next[i]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid    <= '0;
            r_inflight <= '0;
        end else begin
            r_valid    <= w_valid_next;
            r_inflight <= w_inflight_next;
        end
    end

    // Tags are qualified by the valid bits, so they need no reset.
    always_ff @(posedge i_clk) begin
        if (w_fire && w_alloc) begin
            r_tag[w_free_slot] <= i_issue_rd;
        end
    end

endmodule
